uart_rx_buffer: RTL
===================

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the FIFO entry count (power of two, 2..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the consecutive stable clk cycles needed to accept a button level (10 ms at 50 MHz).
REQ-003 clk  in  1  system clock, 50 MHz; all state SHALL be clocked on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 rx_data  in  8  byte from the UART receiver.
REQ-006 rx_valid  in  1  one-cycle strobe; rx_data and rx_perr are valid in that cycle.
REQ-007 rx_perr  in  1  parity error flag for the byte.
REQ-008 btn_pop  in  1  raw, asynchronous, active-low push button; a press requests a pop.
REQ-009 ovf_clr  in  1  synchronous clear of the overflow flag.
REQ-010 head_data  out  8  oldest stored byte; 0 when empty.
REQ-011 head_perr  out  1  parity flag of the oldest entry; 0 when empty.
REQ-012 count  out  $clog2(DEPTH)+1  number of stored entries, range 0..DEPTH.
REQ-013 empty  out  1  count==0.
REQ-014 full  out  1  count==DEPTH.
REQ-015 overflow  out  1  sticky flag: a byte was dropped.

Function
REQ-016 Each entry SHALL hold 9 bits: {perr, data}.
REQ-017 On rx_valid with full=0, the entry SHALL be written at wr_ptr, wr_ptr SHALL increment, and count SHALL increment.
REQ-018 On rx_valid with full=1 and no pop in the same cycle, the byte SHALL be dropped and overflow SHALL be set on the next edge.
REQ-019 A pop event SHALL be a single-cycle pulse, generated when the debounced button level goes 1->0.
REQ-020 On a pop with empty=0, rd_ptr SHALL increment and count SHALL decrement; a pop with empty=1 SHALL be ignored.
REQ-021 Push and pop in the same cycle, not full and not empty: both SHALL occur and count SHALL be unchanged.
REQ-022 Push and pop in the same cycle, full: both SHALL occur, count SHALL stay DEPTH, and overflow SHALL NOT be set.
REQ-023 Push and pop in the same cycle, empty: the push SHALL occur, the pop SHALL be ignored, and count SHALL become 1.
REQ-024 Pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special case.
REQ-025 head_data and head_perr SHALL be show-ahead: registered outputs that reflect mem[rd_ptr] one cycle after any push or pop that changes the head.
REQ-026 Empty to first push: head_data SHALL be valid on the cycle after the rx_valid strobe.
REQ-027 Debounce: btn_pop SHALL pass through a 2-flop synchronizer.
REQ-028 Debounce: the stable level SHALL update only after DEBOUNCE_CYCLES consecutive equal synchronized samples that differ from the current stable level.
REQ-029 Debounce: any bounce SHALL restart the counter.
REQ-030 ovf_clr=1 SHALL clear overflow; if ovf_clr and an overflow drop occur in the same cycle, set SHALL win.
REQ-031 empty, full and count SHALL be registered or derived from registered count, with no combinational path from rx_valid.

Reset
REQ-032 rst=1 SHALL asynchronously force wr_ptr=0, rd_ptr=0, count=0, overflow=0, head_data=0 and head_perr=0.
REQ-033 rst=1 SHALL force the debounced stable level to 1 (released), the debounce counter to 0, and both synchronizer flops to 1.
REQ-034 Storage array contents need no reset.
REQ-035 After reset: empty=1 and full=0.
REQ-036 Reset asserted mid-operation SHALL discard all entries, and no pop pulse SHALL be emitted on release.

Structure
REQ-037 Package uart_pkg SHALL hold UART_DATA_W=8 and the entry type (perr plus 8-bit data).
REQ-038 The synchronizer, debounce counter and falling-edge detector SHALL be one sub-module, btn_debounce (ports clk, rst, btn_n, press_pulse).
REQ-039 The FIFO storage and pointers SHALL stay inline in uart_rx_buffer.

Verification (DEBOUNCE_CYCLES=4, DEPTH=8)
REQ-040 Push 0x41, then 0x42 with perr=1 -> count=2, head_data=0x41, head_perr=0; after one clean press -> head_data=0x42, head_perr=1, count=1.
REQ-041 Push 9 bytes 0x00..0x08 with no pop -> full=1, count=8, overflow=1, head_data=0x00; pop 8 times -> data 0x00..0x07 in order, then empty=1 and head_data=0.
REQ-042 Full FIFO with rx_valid coinciding with a pop pulse -> count stays 8, overflow stays 0, and the new byte is read last.
REQ-043 btn_pop bounces 0/1 every 2 cycles for 20 cycles, then holds 0 -> exactly one pop pulse, about 4+2 cycles after the hold begins; the release produces none.
REQ-044 Pop with the FIFO empty -> count stays 0, empty stays 1, and the pointers are unchanged (a later push is read correctly).
REQ-045 Assert rst with 5 entries stored and btn_pop held low -> all outputs are at reset values immediately; after release, with the button released, no pop occurs, and ovf_clr with a simultaneous drop leaves overflow=1.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared widths and FIFO entry type for the UART receive buffer
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef struct packed {
        logic                   perr;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronizer, debounce counter and press detector for an active-low button
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Flops reset to the released level so leaving reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            stable      <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync1       <= btn_n;
            sync2       <= sync1;
            press_pulse <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable      <= sync2;
                cnt         <= '0;
                press_pulse <= ~sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - show-ahead FIFO of received UART bytes, popped by a debounced button
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [UART_DATA_W-1:0]     rx_data,
    input  logic                       rx_valid,
    input  logic                       rx_perr,
    input  logic                       btn_pop,
    input  logic                       ovf_clr,
    output logic [UART_DATA_W-1:0]     head_data,
    output logic                       head_perr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rx_entry_t        mem [DEPTH];
    rx_entry_t        in_entry;
    rx_entry_t        head_r;
    rx_entry_t        head_next;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next;
    logic             pop;
    logic             pop_ok;
    logic             push;
    logic             drop;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_pop),
        .press_pulse(pop)
    );

    assign empty     = (count_r == '0);
    assign full      = (count_r == CNT_W'(DEPTH));
    assign count     = count_r;
    assign head_data = head_r.data;
    assign head_perr = head_r.perr;

    always_comb begin
        in_entry = '{perr: rx_perr, data: rx_data};
        pop_ok   = pop && !empty;
        push     = rx_valid && (!full || pop);
        drop     = rx_valid && full && !pop;
        rd_next  = pop_ok ? rd_ptr + PTR_W'(1) : rd_ptr;
        case ({push, pop_ok})
            2'b10:   count_next = count_r + CNT_W'(1);
            2'b01:   count_next = count_r - CNT_W'(1);
            default: count_next = count_r;
        endcase
        // The incoming byte bypasses storage when it lands exactly at the new head.
        if (count_next == '0)
            head_next = '0;
        else if (push && (rd_next == wr_ptr))
            head_next = in_entry;
        else
            head_next = mem[rd_next];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_r  <= '0;
            head_r   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr  <= rd_next;
            count_r <= count_next;
            head_r  <= head_next;
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_entry;
    end

endmodule
